// File: rtl/mul_div_unit_pkg.sv
// Shared types for the execute-stage functional units: the functional-unit
// selector, the RV32M multiply/divide opcode, the mul/div FSM states and
// small opcode-classification helpers.
package mul_div_unit_pkg;

    // Functional units reachable from the execute stage.
    typedef enum logic [1:0] {
        FU_ALU    = 2'd0,
        FU_MULDIV = 2'd1,
        FU_LSU    = 2'd2,
        FU_BRANCH = 2'd3
    } fu_t;

    // RV32M operations, encoded in funct3 order.
    typedef enum logic [2:0] {
        MUL    = 3'd0,
        MULH   = 3'd1,
        MULHSU = 3'd2,
        MULHU  = 3'd3,
        DIV    = 3'd4,
        DIVU   = 3'd5,
        REM    = 3'd6,
        REMU   = 3'd7
    } muldiv_op_t;

    // Iterative unit states; exported on the debug port.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } muldiv_state_t;

    // Acceptance cycle to first cycle with a valid result.
    localparam int MULDIV_LATENCY = 34;

    // rs1 is interpreted as a signed value.
    function automatic logic op_signed_a(input muldiv_op_t op);
        return op inside {MUL, MULH, MULHSU, DIV, REM};
    endfunction

    // rs2 is interpreted as a signed value.
    function automatic logic op_signed_b(input muldiv_op_t op);
        return op inside {MUL, MULH, DIV, REM};
    endfunction

    // Divide-class operation (quotient or remainder).
    function automatic logic op_is_div(input muldiv_op_t op);
        return op inside {DIV, DIVU, REM, REMU};
    endfunction

    // Remainder-producing operation.
    function automatic logic op_is_rem(input muldiv_op_t op);
        return op inside {REM, REMU};
    endfunction

endpackage

// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide unit. One 33-bit add/sub datapath is
// shared by shift-add multiplication and restoring division, sequenced
// over XLEN iterations, followed by a sign-fixup cycle.
//
// Handshake: a request is taken on a rising edge where reqValid && reqReady
// (and no flush); a response is taken on a rising edge where
// respValid && respReady. reqReady depends on state only; respValid,
// respRd and respVal are registered and held until the response is taken.
module mul_div_unit
    import mul_div_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            reqValid,
    output logic            reqReady,
    input  muldiv_op_t      reqOp,
    input  logic [XLEN-1:0] reqS1,
    input  logic [XLEN-1:0] reqS2,
    input  logic [4:0]      reqRd,
    input  logic            flush,
    output logic            respValid,
    input  logic            respReady,
    output logic [4:0]      respRd,
    output logic [XLEN-1:0] respVal,
    output logic            busy,
    output muldiv_state_t   dbgState
);

    localparam logic [5:0]        CNT_LAST = 6'(XLEN - 1);
    localparam logic [XLEN-1:0]   INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [2*XLEN-1:0] ONE_W    = {{(2*XLEN-1){1'b0}}, 1'b1};

    muldiv_state_t     r_state;
    muldiv_state_t     w_next_state;
    muldiv_op_t        r_op;
    logic [4:0]        r_rd;
    logic              r_neg_a;
    logic              r_neg_b;
    logic [5:0]        r_cnt;
    logic [2*XLEN-1:0] r_acc;
    logic [XLEN-1:0]   r_opnd;
    logic              r_resp_valid;
    logic [4:0]        r_resp_rd;
    logic [XLEN-1:0]   r_resp_val;

    logic              w_accept;
    logic              w_req_div;
    logic              w_req_rem;
    logic              w_div0;
    logic              w_ovf;
    logic              w_special;
    logic [XLEN-1:0]   w_special_val;
    logic              w_neg_a;
    logic              w_neg_b;
    logic [XLEN-1:0]   w_abs_a;
    logic [XLEN-1:0]   w_abs_b;

    logic              w_is_div;
    logic [XLEN:0]     w_add_a;
    logic [XLEN:0]     w_add_b;
    logic [XLEN+1:0]   w_sum;
    logic [2*XLEN-1:0] w_acc_next;

    logic [2*XLEN-1:0] w_fix_in;
    logic [2*XLEN-1:0] w_fix_neg;
    logic [2*XLEN-1:0] w_fix_val;
    logic              w_fix_negate;
    logic [XLEN-1:0]   w_result;

    assign reqReady  = (r_state == IDLE);
    assign busy      = (r_state != IDLE);
    assign dbgState  = r_state;
    assign respValid = r_resp_valid;
    assign respRd    = r_resp_rd;
    assign respVal   = r_resp_val;

    // Request decode: sign flags, operand magnitudes and the two divide
    // cases that are answered immediately without iterating.
    always_comb begin
        w_req_div     = op_is_div(reqOp);
        w_req_rem     = op_is_rem(reqOp);
        w_neg_a       = op_signed_a(reqOp) && reqS1[XLEN-1];
        w_neg_b       = op_signed_b(reqOp) && reqS2[XLEN-1];
        w_abs_a       = w_neg_a ? -reqS1 : reqS1;
        w_abs_b       = w_neg_b ? -reqS2 : reqS2;
        w_div0        = w_req_div && (reqS2 == '0);
        w_ovf         = (reqOp == DIV || reqOp == REM) &&
                        (reqS1 == INT_MIN) && (reqS2 == '1);
        w_special     = w_div0 || w_ovf;
        w_special_val = '0;
        if (w_div0)
            w_special_val = w_req_rem ? reqS1 : '1;
        else if (w_ovf)
            w_special_val = w_req_rem ? '0 : INT_MIN;
    end

    // Shared iteration datapath. Multiply: acc = {hi, multiplier}, add the
    // multiplicand into hi when the LSB is set, then shift right with the
    // carry. Divide: acc = {rem, dividend}, shift left and trial-subtract;
    // carry-out of rem + ~divisor + 1 means the result is non-negative.
    always_comb begin
        w_is_div = op_is_div(r_op);
        w_add_a  = w_is_div ? r_acc[2*XLEN-1:XLEN-1] : {1'b0, r_acc[2*XLEN-1:XLEN]};
        w_add_b  = w_is_div ? ~{1'b0, r_opnd} : {1'b0, r_opnd};
        w_sum    = {1'b0, w_add_a} + {1'b0, w_add_b} + {{(XLEN+1){1'b0}}, w_is_div};
        if (w_is_div) begin
            if (w_sum[XLEN+1])
                w_acc_next = {w_sum[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};
            else
                w_acc_next = {r_acc[2*XLEN-2:0], 1'b0};
        end else begin
            if (r_acc[0])
                w_acc_next = {w_sum[XLEN:0], r_acc[XLEN-1:1]};
            else
                w_acc_next = {1'b0, r_acc[2*XLEN-1:1]};
        end
    end

    // Sign fixup and result selection, through one 2*XLEN negation stage.
    always_comb begin
        w_fix_in     = r_acc;
        w_fix_negate = r_neg_a ^ r_neg_b;
        if (op_is_rem(r_op)) begin
            w_fix_in     = {{XLEN{1'b0}}, r_acc[2*XLEN-1:XLEN]};
            w_fix_negate = r_neg_a;
        end else if (op_is_div(r_op)) begin
            w_fix_in     = {{XLEN{1'b0}}, r_acc[XLEN-1:0]};
        end
        w_fix_neg = ~w_fix_in + ONE_W;
        w_fix_val = w_fix_negate ? w_fix_neg : w_fix_in;
        case (r_op)
            MULH, MULHSU, MULHU: w_result = w_fix_val[2*XLEN-1:XLEN];
            default:             w_result = w_fix_val[XLEN-1:0];
        endcase
    end

    // Next-state logic; flush overrides every transition and blocks acceptance.
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        case (r_state)
            IDLE: begin
                if (reqValid) begin
                    w_accept     = 1'b1;
                    w_next_state = w_special ? DONE : ITER;
                end
            end
            ITER:    if (r_cnt == CNT_LAST) w_next_state = FIX;
            FIX:     w_next_state = DONE;
            DONE:    if (respReady) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
        if (flush) begin
            w_next_state = IDLE;
            w_accept     = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst)
            r_state <= IDLE;
        else
            r_state <= w_next_state;
    end

    // Operand latching, iteration, and registered response.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt        <= '0;
            r_resp_valid <= 1'b0;
            r_resp_rd    <= '0;
            r_resp_val   <= '0;
        end else if (flush) begin
            r_cnt        <= '0;
            r_resp_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_op    <= reqOp;
                        r_rd    <= reqRd;
                        r_neg_a <= w_neg_a;
                        r_neg_b <= w_neg_b;
                        r_cnt   <= '0;
                        r_opnd  <= w_abs_b;
                        r_acc   <= {{XLEN{1'b0}}, w_abs_a};
                        if (w_special) begin
                            r_resp_valid <= 1'b1;
                            r_resp_rd    <= reqRd;
                            r_resp_val   <= w_special_val;
                        end
                    end
                end
                ITER: begin
                    r_acc <= w_acc_next;
                    r_cnt <= r_cnt + 6'd1;
                end
                FIX: begin
                    r_resp_valid <= 1'b1;
                    r_resp_rd    <= r_rd;
                    r_resp_val   <= w_result;
                end
                DONE: begin
                    if (respReady)
                        r_resp_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
